dout_display: RTL

- Output stage directly downstream of the CPU. Consumes its `Dout`/`Dval` data strobe and `IP` bus.
- Drives a 4-digit multiplexed seven-segment display.
- Hex mode: shows `IP` (digits 3–2) and the last valid `Dout` byte (digits 1–0).
- Decimal mode: shows the last valid byte as 0–255, converted by a sequential shift-add-3 (double-dabble) converter.

---
 rtl/dout_display_pkg.sv | 77 +++++++
 rtl/dout_display_bin_to_bcd.sv | 73 +++++++
 rtl/dout_display.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dout_display_pkg.sv
// -----------------------------------------------------------------------------
// dout_display_pkg
// Shared definitions for the CPU output display stage:
//   - active-low seven-segment glyphs (bit order gfedcba)
//   - binary-to-BCD converter state encoding
//   - hex-nibble-to-glyph decode and one double-dabble step
// -----------------------------------------------------------------------------
package dout_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_e;

    // Hex nibble to active-low glyph.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // One shift-add-3 iteration on {hundreds, tens, units, binary}:
    // correct every BCD nibble >= 5, then shift the whole word left by one.
    function automatic logic [19:0] dabble_step(input logic [19:0] word);
        logic [19:0] adj;
        adj = word;
        if (adj[11:8] >= 4'd5) begin
            adj[11:8] = adj[11:8] + 4'd3;
        end
        if (adj[15:12] >= 4'd5) begin
            adj[15:12] = adj[15:12] + 4'd3;
        end
        if (adj[19:16] >= 4'd5) begin
            adj[19:16] = adj[19:16] + 4'd3;
        end
        return {adj[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/dout_display_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
// Ports:
//   Clock, Reset  - clock, synchronous active-high reset
//   Start         - load Bin and (re)start a conversion; aborts any in flight
//   Bin[7:0]      - binary value to convert
//   Busy          - high while a conversion is in progress (SHIFT/DONE)
//   Bcd[11:0]     - last completed result {hundreds, tens, units}
// The result register only ever receives a completed conversion, so an
// aborted conversion never becomes visible.
// -----------------------------------------------------------------------------
module bin_to_bcd
    import dout_display_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  Bin,
    output logic        Busy,
    output logic [11:0] Bcd
);

    bcd_state_e  state_r;
    logic [19:0] shift_r;
    logic [2:0]  count_r;
    logic [11:0] bcd_r;
    logic        busy_r;

    // Converter FSM: a Start always wins and reloads the shift register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            shift_r <= 20'd0;
            count_r <= 3'd0;
            bcd_r   <= 12'd0;
            busy_r  <= 1'b0;
        end else if (Start) begin
            state_r <= ST_SHIFT;
            shift_r <= {12'd0, Bin};
            count_r <= 3'd0;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                end
                ST_SHIFT: begin
                    shift_r <= dabble_step(shift_r);
                    count_r <= count_r + 3'd1;
                    busy_r  <= 1'b1;
                    // count_r == 7 is the eighth and final iteration
                    if (count_r == 3'd7) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_r   <= shift_r[19:8];
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_r;
    assign Bcd  = bcd_r;

endmodule

// File: rtl/dout_display.sv
// -----------------------------------------------------------------------------
// dout_display
// Output stage behind the CPU: drives a 4-digit multiplexed, active-low
// seven-segment display.
// Ports:
//   Clock, Reset  - clock, synchronous active-high reset
//   Dout[7:0]     - data byte from the CPU, valid when Dval is high
//   Dval          - one-cycle data strobe
//   IP[7:0]       - CPU instruction pointer, shown live in hex view
//   DecMode       - 0 = hex view (IP | data), 1 = decimal view of data
//   Segments[6:0] - active-low segments, gfedcba
//   Digits[3:0]   - active-low digit enables, digit 3 leftmost
//   DP            - active-low decimal point (lit on digit 2 in hex view)
//   Busy          - BCD conversion in progress
// All display outputs are registered and lag the refresh counter by a cycle.
// -----------------------------------------------------------------------------
module dout_display
    import dout_display_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Dout,
    input  logic       Dval,
    input  logic [7:0] IP,
    input  logic       DecMode,
    output logic [6:0] Segments,
    output logic [3:0] Digits,
    output logic       DP,
    output logic       Busy
);

    logic [REFRESH_BITS-1:0] refresh_r;
    logic [7:0]              data_r;
    logic                    valid_r;
    logic [6:0]              seg_r;
    logic [3:0]              dig_r;
    logic                    dp_r;

    logic [1:0]  sel_s;
    logic [6:0]  seg_s;
    logic [3:0]  dig_s;
    logic        dp_s;
    logic [11:0] bcd_s;
    logic        conv_busy_s;
    logic [3:0]  hund_s;
    logic [3:0]  tens_s;
    logic [3:0]  units_s;

    bin_to_bcd u_bcd (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Dval),
        .Bin   (Dout),
        .Busy  (conv_busy_s),
        .Bcd   (bcd_s)
    );

    assign sel_s   = refresh_r[REFRESH_BITS-1 -: 2];
    assign hund_s  = bcd_s[11:8];
    assign tens_s  = bcd_s[7:4];
    assign units_s = bcd_s[3:0];

    // Glyph, digit enable and decimal point for the currently selected digit.
    always_comb begin
        seg_s = SEG_BLANK;
        dp_s  = 1'b1;
        dig_s = ~(4'b0001 << sel_s);
        if (!DecMode) begin
            case (sel_s)
                2'd3: seg_s = hex_to_seg(IP[7:4]);
                2'd2: begin
                    seg_s = hex_to_seg(IP[3:0]);
                    dp_s  = 1'b0;
                end
                2'd1: seg_s = valid_r ? hex_to_seg(data_r[7:4]) : SEG_DASH;
                2'd0: seg_s = valid_r ? hex_to_seg(data_r[3:0]) : SEG_DASH;
                default: seg_s = SEG_BLANK;
            endcase
        end else begin
            case (sel_s)
                2'd3: seg_s = SEG_BLANK;
                2'd2: begin
                    if (!valid_r) begin
                        seg_s = SEG_DASH;
                    end else if (hund_s == 4'd0) begin
                        seg_s = SEG_BLANK;
                    end else begin
                        seg_s = hex_to_seg(hund_s);
                    end
                end
                2'd1: begin
                    if (!valid_r) begin
                        seg_s = SEG_DASH;
                    end else if ((hund_s == 4'd0) && (tens_s == 4'd0)) begin
                        seg_s = SEG_BLANK;
                    end else begin
                        seg_s = hex_to_seg(tens_s);
                    end
                end
                2'd0: seg_s = valid_r ? hex_to_seg(units_s) : SEG_DASH;
                default: seg_s = SEG_BLANK;
            endcase
        end
    end

    // Refresh counter, data capture and registered display outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            refresh_r <= '0;
            data_r    <= 8'd0;
            valid_r   <= 1'b0;
            seg_r     <= SEG_BLANK;
            dig_r     <= 4'b1111;
            dp_r      <= 1'b1;
        end else begin
            refresh_r <= refresh_r + REFRESH_BITS'(1);
            if (Dval) begin
                data_r  <= Dout;
                valid_r <= 1'b1;
            end
            seg_r <= seg_s;
            dig_r <= dig_s;
            dp_r  <= dp_s;
        end
    end

    assign Segments = seg_r;
    assign Digits   = dig_r;
    assign DP       = dp_r;
    assign Busy     = conv_busy_s;

endmodule
